mutidata_rx_hs: RTL and testbench
=================================

# mutidata_rx_hs

Destination-side endpoint of the multi-bit CDC handshake: it receives a 4-phase request level and a held data bus from a foreign clock domain, synchronizes the request, captures the word, returns an acknowledge level and presents the word locally with a valid/ready handshake. It sits in the receiving (`clk_o`) domain, opposite the transmitter that drives `req_i`/`data_i` and waits on `ack_o`. Backpressure from the local consumer stalls the acknowledge, so no word is ever dropped.

## Interface
- `WIDTH`, 8: data bus width.
- `SYNC_STAGES`, 2: flops in the `req_i` synchronizer; legal values ≥ 2.

- `clk_o`  in  1  receiving-domain clock; the only clock.
- `rst_o`  in  1  asynchronous, active-low reset.
- `req_i`  in  1  request level from the transmitter domain (asynchronous to `clk_o`).
- `data_i`  in  WIDTH  data from the transmitter; stable from before `req_i` rises until `ack_o` is seen high.
- `ack_o`  out  1  registered acknowledge level to the transmitter.
- `dout`  out  WIDTH  captured word.
- `out_valid`  out  1  `dout` holds an unconsumed word.
- `out_ready`  in  1  consumer accepts `dout` this cycle.
- `out_pulse`  out  1  one-cycle strobe: new word loaded into `dout`.
- `rx_count`  out  8  number of words captured, modulo 256.

## Operation
- `req_i` passes through `SYNC_STAGES` flops; `req_s` is the last flop. `data_i` is never synchronized; it is sampled only when `req_s` is 1.
- Buffer free: `buf_free = !out_valid || out_ready`.
- FSM states:
  - IDLE (`ack_o`=0): `req_s`=1 and `buf_free` → capture, go HOLD. `req_s`=1 and not `buf_free` → STALL. Otherwise stay.
  - STALL (`ack_o`=0): `buf_free` → capture, go HOLD. Otherwise stay. `req_s` is not re-checked here, because the transmitter cannot drop `req_i` before seeing ack.
  - HOLD (`ack_o`=1): `req_s`=0 → `ack_o`←0, go IDLE. Otherwise stay.
- Capture, all registered on the same edge:
  - `dout`←`data_i`, `out_valid`←1, `out_pulse`←1, `ack_o`←1.
  - `rx_count`←`rx_count`+1, wrapping 255→0.
- `out_pulse` is 0 on every edge without a capture.
- `out_valid`←0 when `out_ready`=1 and there is no capture on that edge.
- A capture with `out_ready`=1 on the same edge replaces `dout`; `out_valid` stays 1.
- `out_ready` is ignored while `out_valid`=0.
- IDLE never re-captures during the `req_i`-low phase, so each 4-phase cycle yields exactly one word.
- Illegal state encodings return to IDLE.

## Timing
- Reset values, all applied immediately on assertion of `rst_o`: `ack_o`=0, `dout`=0, `out_valid`=0, `out_pulse`=0, `rx_count`=0, synchronizer=0, FSM=IDLE.
- `req_i` rising before edge 1 → `ack_o`, `dout`, `out_valid`, `out_pulse` high after edge `SYNC_STAGES`+1 when the buffer is free. The default gives 3 `clk_o` edges.
- `req_i` falling before edge 1 → `ack_o` low after edge `SYNC_STAGES`+1.
- Stall: capture occurs on the first edge where `buf_free`=1, and `ack_o` rises on that same edge.
- Maximum throughput is one word per full 4-phase round trip. This is at least 2×(`SYNC_STAGES`+1) `clk_o` cycles plus the transmitter's synchronizer latency.
- Reset mid-transfer: `ack_o` drops and the word in `dout` is lost. If `req_i` is still high after reset release, the word is captured again. Both domains are required to reset together.

## Test plan
- Single transfer: `data_i`=8'h05, `req_i` 0→1 → `ack_o`=1, `dout`=8'h05, `out_valid`=1 after 3 edges. `out_pulse` is high for exactly 1 cycle and `rx_count`=1. Drop `req_i` → `ack_o`=0 3 edges later.
- Sequence of 5 words: 8'd5, 8'd11, 8'd4, 8'd8, 8'd14, each held until ack, with `out_ready`=1 → 5 `out_pulse` strobes with matching `dout` values in order, `rx_count`=5, no duplicates.
- Backpressure: `out_ready`=0 and word 8'hA1 pending, then `req_i` rises with 8'hB2 → FSM in STALL and `ack_o` stays 0. Pulse `out_ready` for 1 cycle → `dout`=8'hB2 and `ack_o`=1 on that edge, `out_valid` stays 1.
- Simultaneous consume and capture: `out_valid`=1 and `out_ready`=1 on the capture edge → `dout` updates, `out_valid` stays 1, `rx_count` increments by 1.
- Wrap and reset: 256 transfers → `rx_count` returns to 0. Assert `rst_o`=0 while in HOLD → all outputs 0 immediately. Release with `req_i`=1 → recapture after 3 edges.
- Random phase: `req_i` toggled at random offsets relative to `clk_o` (asynchronous to it) over 1000 transfers → every word received exactly once, in order.

Source files
------------

// File: rtl/mutidata_rx_hs.sv
// Purpose: receive side of a 4-phase multi-bit CDC handshake; syncs req, captures held data, returns ack.
// Latency: word visible on dout/out_valid/out_pulse SYNC_STAGES+1 clk_o edges after req_i rises.
// Backpressure: out_ready low with a pending word parks the FSM in STALL and withholds ack_o.
module mutidata_rx_hs #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_o,
    input  logic             rst_o,
    input  logic             req_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             ack_o,
    output logic [WIDTH-1:0] dout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_pulse,
    output logic [7:0]       rx_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STALL = 2'd1,
        HOLD  = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] req_sync;
    logic                   req_s;
    logic                   buf_free;
    logic                   capture;
    state_t                 state_q;
    state_t                 state_d;

    assign req_s    = req_sync[SYNC_STAGES-1];
    assign buf_free = !out_valid || out_ready;

    // Request level synchronizer; data_i is only sampled once req_s is high.
    always_ff @(posedge clk_o or negedge rst_o) begin
        if (!rst_o) begin
            req_sync <= '0;
        end else begin
            req_sync <= {req_sync[SYNC_STAGES-2:0], req_i};
        end
    end

    // Handshake FSM state register.
    always_ff @(posedge clk_o or negedge rst_o) begin
        if (!rst_o) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and capture decision; STALL trusts req to stay high until ack is seen.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_s) begin
                    if (buf_free) begin
                        capture = 1'b1;
                        state_d = HOLD;
                    end else begin
                        state_d = STALL;
                    end
                end
            end
            STALL: begin
                if (buf_free) begin
                    capture = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (!req_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Ack is high exactly while the FSM sits in HOLD, registered to avoid glitches across domains.
    always_ff @(posedge clk_o or negedge rst_o) begin
        if (!rst_o) begin
            ack_o <= 1'b0;
        end else begin
            ack_o <= (state_d == HOLD);
        end
    end

    // Output buffer: load on capture, otherwise drain when the consumer takes the word.
    always_ff @(posedge clk_o or negedge rst_o) begin
        if (!rst_o) begin
            dout      <= '0;
            out_valid <= 1'b0;
            out_pulse <= 1'b0;
            rx_count  <= 8'd0;
        end else begin
            out_pulse <= capture;
            if (capture) begin
                dout      <= data_i;
                out_valid <= 1'b1;
                rx_count  <= rx_count + 8'd1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mutidata_rx_hs.sv
module tb_mutidata_rx_hs;

    logic       clk_o = 1'b0;
    logic       rst_o;
    logic       req_i;
    logic [7:0] data_i;
    logic       ack_o;
    logic [7:0] dout;
    logic       out_valid;
    logic       out_ready;
    logic       out_pulse;
    logic [7:0] rx_count;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_cnt = 8'd0;
    bit         tx_done;

    always #5 clk_o = ~clk_o;

    mutidata_rx_hs #(.WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk_o     (clk_o),
        .rst_o     (rst_o),
        .req_i     (req_i),
        .data_i    (data_i),
        .ack_o     (ack_o),
        .dout      (dout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pulse (out_pulse),
        .rx_count  (rx_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Bounded wait for ack_o to reach a level; an expired budget shows up as a failed check.
    task automatic wait_ack(input logic lvl, input string tag);
        int n = 0;
        while (ack_o !== lvl && n < 300) begin
            @(posedge clk_o);
            #1;
            n++;
        end
        chk(tag, {31'd0, ack_o}, {31'd0, lvl});
    endtask

    // Transmitter model: full 4-phase round trip with req edges at random phase.
    task automatic xfer(input logic [7:0] d);
        data_i = d;
        exp_q.push_back(d);
        @(posedge clk_o);
        #($urandom_range(1, 9));
        req_i = 1'b1;
        wait_ack(1'b1, "ack_rise");
        repeat ($urandom_range(0, 3)) @(posedge clk_o);
        #($urandom_range(1, 9));
        req_i = 1'b0;
        wait_ack(1'b0, "ack_fall");
    endtask

    // Scoreboard: each load strobe must deliver the next sent word, and the count must track it.
    initial begin
        forever begin
            @(negedge clk_o);
            if (!rst_o) begin
                exp_cnt = 8'd0;
            end else if (out_pulse) begin
                exp_cnt = exp_cnt + 8'd1;
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", {24'd0, dout}, 32'hFFFF_FFFF);
                end else begin
                    chk("word", {24'd0, dout}, {24'd0, exp_q.pop_front()});
                end
                chk("rx_count", {24'd0, rx_count}, {24'd0, exp_cnt});
            end
        end
    end

    initial begin
        logic [7:0] cnt_before;
        int         n;
        rst_o     = 1'b0;
        req_i     = 1'b0;
        data_i    = 8'd0;
        out_ready = 1'b0;
        tx_done   = 1'b0;
        #2;
        chk("rst_ack", {31'd0, ack_o}, 0);
        chk("rst_dout", {24'd0, dout}, 0);
        chk("rst_valid", {31'd0, out_valid}, 0);
        chk("rst_pulse", {31'd0, out_pulse}, 0);
        chk("rst_count", {24'd0, rx_count}, 0);
        repeat (3) @(negedge clk_o);
        rst_o = 1'b1;

        // Single transfer with exact latency.
        @(negedge clk_o);
        data_i = 8'h05;
        exp_q.push_back(8'h05);
        req_i = 1'b1;
        @(posedge clk_o); #1;
        chk("lat_e1_ack", {31'd0, ack_o}, 0);
        @(posedge clk_o); #1;
        chk("lat_e2_ack", {31'd0, ack_o}, 0);
        chk("lat_e2_valid", {31'd0, out_valid}, 0);
        @(posedge clk_o); #1;
        chk("lat_e3_ack", {31'd0, ack_o}, 1);
        chk("lat_e3_dout", {24'd0, dout}, 32'h05);
        chk("lat_e3_valid", {31'd0, out_valid}, 1);
        chk("lat_e3_pulse", {31'd0, out_pulse}, 1);
        chk("lat_e3_count", {24'd0, rx_count}, 1);
        @(posedge clk_o); #1;
        chk("pulse_once", {31'd0, out_pulse}, 0);
        chk("valid_held", {31'd0, out_valid}, 1);
        @(negedge clk_o);
        req_i = 1'b0;
        @(posedge clk_o); #1;
        @(posedge clk_o); #1;
        chk("fall_e2_ack", {31'd0, ack_o}, 1);
        @(posedge clk_o); #1;
        chk("fall_e3_ack", {31'd0, ack_o}, 0);
        @(negedge clk_o);
        out_ready = 1'b1;
        @(posedge clk_o); #1;
        chk("consumed", {31'd0, out_valid}, 0);

        // Five-word sequence with the consumer always ready.
        xfer(8'd5); xfer(8'd11); xfer(8'd4); xfer(8'd8); xfer(8'd14);
        chk("seq_count", {24'd0, rx_count}, 6);

        // Backpressure: A1 left pending, B2 must stall without ack.
        @(negedge clk_o);
        out_ready = 1'b0;
        xfer(8'hA1);
        @(negedge clk_o);
        data_i = 8'hB2;
        exp_q.push_back(8'hB2);
        req_i = 1'b1;
        repeat (6) @(posedge clk_o);
        #1;
        chk("stall_ack", {31'd0, ack_o}, 0);
        chk("stall_dout", {24'd0, dout}, 32'hA1);
        chk("stall_valid", {31'd0, out_valid}, 1);
        @(negedge clk_o);
        out_ready = 1'b1;
        @(posedge clk_o); #1;
        chk("unstall_dout", {24'd0, dout}, 32'hB2);
        chk("unstall_ack", {31'd0, ack_o}, 1);
        chk("unstall_valid", {31'd0, out_valid}, 1);
        @(negedge clk_o);
        out_ready = 1'b0;
        req_i = 1'b0;
        wait_ack(1'b0, "unstall_fall");

        // Consume and capture on the same edge (B2 still pending).
        @(negedge clk_o);
        cnt_before = exp_cnt;
        data_i = 8'h3C;
        exp_q.push_back(8'h3C);
        req_i = 1'b1;
        @(posedge clk_o);
        @(posedge clk_o);
        @(negedge clk_o);
        out_ready = 1'b1;
        @(posedge clk_o); #1;
        chk("simul_dout", {24'd0, dout}, 32'h3C);
        chk("simul_valid", {31'd0, out_valid}, 1);
        chk("simul_count", {24'd0, rx_count}, {24'd0, cnt_before + 8'd1});
        @(negedge clk_o);
        req_i = 1'b0;
        wait_ack(1'b0, "simul_fall");

        // Run the counter around to zero.
        n = 256 - int'(exp_cnt);
        for (int i = 0; i < n; i++) xfer(8'($urandom));
        chk("wrap", {24'd0, rx_count}, 0);

        // Reset while in HOLD, then recapture with req still high.
        @(negedge clk_o);
        data_i = 8'h77;
        exp_q.push_back(8'h77);
        req_i = 1'b1;
        wait_ack(1'b1, "hold_ack");
        @(negedge clk_o);
        #1;
        rst_o = 1'b0;
        #1;
        chk("mid_rst_ack", {31'd0, ack_o}, 0);
        chk("mid_rst_dout", {24'd0, dout}, 0);
        chk("mid_rst_valid", {31'd0, out_valid}, 0);
        chk("mid_rst_count", {24'd0, rx_count}, 0);
        exp_q.push_back(8'h77);
        repeat (2) @(negedge clk_o);
        @(posedge clk_o); #3;
        rst_o = 1'b1;
        @(posedge clk_o); #1;
        @(posedge clk_o); #1;
        chk("rel_e2_ack", {31'd0, ack_o}, 0);
        @(posedge clk_o); #1;
        chk("rel_e3_ack", {31'd0, ack_o}, 1);
        chk("rel_e3_dout", {24'd0, dout}, 32'h77);
        chk("rel_e3_count", {24'd0, rx_count}, 1);
        @(negedge clk_o);
        req_i = 1'b0;
        wait_ack(1'b0, "rel_fall");

        // Random phase and random consumer over many transfers.
        fork
            begin
                for (int i = 0; i < 1000; i++) xfer(8'($urandom));
                tx_done = 1'b1;
            end
            begin
                while (!tx_done) begin
                    @(negedge clk_o);
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        repeat (5) @(posedge clk_o);
        #1;
        chk("leftover", exp_q.size(), 0);
        chk("final_count", {24'd0, rx_count}, {24'd0, exp_cnt});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
